// File: rtl/fp16_pkg.sv
// Shared binary16 definitions: field widths, constants, FSM encoding and the classifier payload.
package fp16_pkg;

    localparam int unsigned FP_W   = 16;
    localparam int unsigned EXP_W  = 5;
    localparam int unsigned FRAC_W = 10;
    localparam int unsigned MANT_W = 11;
    localparam int unsigned EXPI_W = 7;
    localparam int unsigned REM_W  = 13;
    localparam int unsigned Q_W    = 12;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BIAS   = 15;

    localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;
    localparam logic [FP_W-1:0]  QNAN    = 16'h7E00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_PREN,
        S_CALC,
        S_NORM,
        S_PACK,
        S_SUBN,
        S_DONE
    } fp_state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              zero;
        logic              sub;
        logic              inf;
        logic              nan;
    } fp16_class_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational binary16 field split and class flags (zero, subnormal, inf, nan).
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [FP_W-1:0] fp_val,
    output fp16_class_t     cls_c
);

    logic exp_zero;
    logic exp_ones;
    logic frac_zero;

    assign exp_zero  = (fp_val[FP_W-2:FRAC_W] == '0);
    assign exp_ones  = (fp_val[FP_W-2:FRAC_W] == EXP_MAX);
    assign frac_zero = (fp_val[FRAC_W-1:0] == '0);

    assign cls_c.sign = fp_val[FP_W-1];
    assign cls_c.exp  = fp_val[FP_W-2:FRAC_W];
    assign cls_c.frac = fp_val[FRAC_W-1:0];
    assign cls_c.zero = exp_zero & frac_zero;
    assign cls_c.sub  = exp_zero & ~frac_zero;
    assign cls_c.inf  = exp_ones & frac_zero;
    assign cls_c.nan  = exp_ones & ~frac_zero;

endmodule

// File: rtl/div.sv
// Sequential binary16 divider: special-case screen, subnormal prenormalise,
// 12-bit restoring division, truncating normalise/pack with gradual underflow.
module div
    import fp16_pkg::*;
#(
    parameter logic [FP_W-1:0] QNAN_VAL = QNAN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [FP_W-1:0] in_a,
    input  logic [FP_W-1:0] in_b,
    output logic [FP_W-1:0] out,
    output logic            done
);

    localparam logic signed [EXPI_W-1:0] E_ZERO = '0;
    localparam logic signed [EXPI_W-1:0] E_ONE  = EXPI_W'(1);
    localparam logic signed [EXPI_W-1:0] E_BIAS = EXPI_W'(BIAS);
    localparam logic signed [EXPI_W-1:0] E_TOP  = EXPI_W'(EXP_MAX);

    fp_state_e state, state_n;

    logic [FP_W-1:0]   a_r, a_n, b_r, b_n;
    logic              sign, sign_n;
    logic [MANT_W-1:0] ma, ma_n, mb, mb_n;
    logic signed [EXPI_W-1:0] ea, ea_n, eb, eb_n, qexp, qexp_n;
    logic signed [EXPI_W-1:0] e_raw, qexp_inc;
    logic [REM_W-1:0]  rem, rem_n, div_rem, div_diff;
    logic              div_ge;
    logic [Q_W-1:0]    q, q_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [MANT_W-1:0] mant, mant_n, mant_sh;
    logic [FP_W-1:0]   out_n;
    logic              done_n;

    fp16_class_t ca, cb;

    fp16_classify u_cls_a (.fp_val(a_r), .cls_c(ca));
    fp16_classify u_cls_b (.fp_val(b_r), .cls_c(cb));

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a_r   <= '0;
            b_r   <= '0;
            sign  <= 1'b0;
            ma    <= '0;
            mb    <= '0;
            ea    <= '0;
            eb    <= '0;
            qexp  <= '0;
            rem   <= '0;
            q     <= '0;
            cnt   <= '0;
            mant  <= '0;
            out   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            a_r   <= a_n;
            b_r   <= b_n;
            sign  <= sign_n;
            ma    <= ma_n;
            mb    <= mb_n;
            ea    <= ea_n;
            eb    <= eb_n;
            qexp  <= qexp_n;
            rem   <= rem_n;
            q     <= q_n;
            cnt   <= cnt_n;
            mant  <= mant_n;
            out   <= out_n;
            done  <= done_n;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n = state;
        a_n     = a_r;
        b_n     = b_r;
        sign_n  = sign;
        ma_n    = ma;
        mb_n    = mb;
        ea_n    = ea;
        eb_n    = eb;
        qexp_n  = qexp;
        rem_n   = rem;
        q_n     = q;
        cnt_n   = cnt;
        mant_n  = mant;
        out_n   = out;
        done_n  = 1'b0;

        // First iteration divides straight from the (prenormalised) dividend
        div_rem  = (cnt == '0) ? REM_W'(ma) : rem;
        div_ge   = (div_rem >= REM_W'(mb));
        div_diff = div_ge ? (div_rem - REM_W'(mb)) : div_rem;
        e_raw    = ea - eb + E_BIAS;
        mant_sh  = mant >> 1;
        qexp_inc = qexp + E_ONE;

        case (state)
            S_IDLE: begin
                if (start) begin
                    a_n     = in_a;
                    b_n     = in_b;
                    state_n = S_INIT;
                end
            end

            S_INIT: begin
                sign_n = ca.sign ^ cb.sign;
                ma_n   = {~ca.sub, ca.frac};
                mb_n   = {~cb.sub, cb.frac};
                ea_n   = (ca.exp == '0) ? E_ONE : EXPI_W'(ca.exp);
                eb_n   = (cb.exp == '0) ? E_ONE : EXPI_W'(cb.exp);
                rem_n  = '0;
                q_n    = '0;
                cnt_n  = '0;
                if (ca.nan || cb.nan || (ca.zero && cb.zero) || (ca.inf && cb.inf)) begin
                    out_n   = QNAN_VAL;
                    state_n = S_DONE;
                end else if (ca.inf || cb.zero) begin
                    out_n   = {sign_n, EXP_MAX, FRAC_W'(0)};
                    state_n = S_DONE;
                end else if (ca.zero || cb.inf) begin
                    out_n   = {sign_n, (FP_W-1)'(0)};
                    state_n = S_DONE;
                end else if (!ma_n[MANT_W-1] || !mb_n[MANT_W-1]) begin
                    state_n = S_PREN;
                end else begin
                    state_n = S_CALC;
                end
            end

            // Dividend normalised first, then divisor; one shift per cycle
            S_PREN: begin
                if (!ma[MANT_W-1]) begin
                    ma_n = ma << 1;
                    ea_n = ea - E_ONE;
                    if (ma[MANT_W-2] && mb[MANT_W-1]) begin
                        state_n = S_CALC;
                    end
                end else begin
                    mb_n = mb << 1;
                    eb_n = eb - E_ONE;
                    if (mb[MANT_W-2]) begin
                        state_n = S_CALC;
                    end
                end
            end

            S_CALC: begin
                rem_n = {div_diff[REM_W-2:0], 1'b0};
                q_n   = {q[Q_W-2:0], div_ge};
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(Q_W - 1)) begin
                    state_n = S_NORM;
                end
            end

            S_NORM: begin
                if (q[Q_W-1]) begin
                    mant_n = q[Q_W-1:1];
                    qexp_n = e_raw;
                end else begin
                    mant_n = q[Q_W-2:0];
                    qexp_n = e_raw - E_ONE;
                end
                state_n = S_PACK;
            end

            S_PACK: begin
                if (qexp >= E_TOP) begin
                    out_n   = {sign, EXP_MAX, FRAC_W'(0)};
                    state_n = S_DONE;
                end else if (qexp <= E_ZERO) begin
                    state_n = S_SUBN;
                end else begin
                    out_n   = {sign, qexp[EXP_W-1:0], mant[FRAC_W-1:0]};
                    state_n = S_DONE;
                end
            end

            // Gradual underflow; an all-zero mantissa packs as signed zero
            S_SUBN: begin
                mant_n = mant_sh;
                qexp_n = qexp_inc;
                if ((mant_sh == '0) || (qexp_inc == E_ONE)) begin
                    out_n   = {sign, EXP_W'(0), mant_sh[FRAC_W-1:0]};
                    state_n = S_DONE;
                end
            end

            S_DONE: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_div.sv
// Directed bench for the binary16 divider: results, latencies, reset abort and back-to-back starts.
module tb_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] out;
    logic        done;

    int checks;
    int failures;

    div #(.QNAN_VAL(16'h7E00)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .in_a (in_a),
        .in_b (in_b),
        .out  (out),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation; lat = edges after the start-sampling edge until done (-1 on timeout)
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] res, output int lat);
        bit seen;
        seen = 1'b0;
        res  = 16'hxxxx;
        lat  = -1;
        @(negedge clk);
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            if (!seen) begin
                @(posedge clk);
                #1;
                if (done) begin
                    res  = out;
                    lat  = i;
                    seen = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] res;
        int lat;
        rst   = 1'b1;
        start = 1'b1;
        in_a  = 16'h3C00;
        in_b  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_out got=%h want=0000", out);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b want=0", done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        res = 16'hxxxx;
        for (int i = 1; i <= 10; i++) begin
            if (lat < 0) begin
                @(posedge clk);
                #1;
                if (done) begin
                    lat = i;
                    res = out;
                end
            end
        end
        checks++;
        if (res !== 16'h7C00) begin
            failures++;
            $display("FAIL post_reset_out got=%h want=7c00", res);
        end
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL post_reset_latency got=%0d want=2", lat);
        end
    endtask

    task automatic test_normal();
        logic [15:0] res;
        int lat;
        run_op(16'h3C00, 16'h4200, res, lat);
        checks++;
        if (res !== 16'h3555) begin
            failures++;
            $display("FAIL one_third_out got=%h want=3555", res);
        end
        checks++;
        if (lat !== 16) begin
            failures++;
            $display("FAIL one_third_latency got=%0d want=16", lat);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_single_cycle got=%b want=0", done);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out !== 16'h3555) begin
            failures++;
            $display("FAIL out_hold got=%h want=3555", out);
        end
        run_op(16'h4600, 16'hC000, res, lat);
        checks++;
        if (res !== 16'hC200) begin
            failures++;
            $display("FAIL neg_div_out got=%h want=c200", res);
        end
        checks++;
        if (lat !== 16) begin
            failures++;
            $display("FAIL neg_div_latency got=%0d want=16", lat);
        end
    endtask

    task automatic test_specials();
        logic [15:0] va [0:6];
        logic [15:0] vb [0:6];
        logic [15:0] ve [0:6];
        logic [15:0] res;
        int lat;
        va = '{16'h3C00, 16'h0000, 16'h7C00, 16'h7C01, 16'h0000, 16'hBC00, 16'hFC00};
        vb = '{16'h0000, 16'h0000, 16'hFC00, 16'h3C00, 16'h3C00, 16'h7C00, 16'h4000};
        ve = '{16'h7C00, 16'h7E00, 16'h7E00, 16'h7E00, 16'h0000, 16'h8000, 16'hFC00};
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], res, lat);
            checks++;
            if (res !== ve[i]) begin
                failures++;
                $display("FAIL special_out[%0d] %h/%h got=%h want=%h", i, va[i], vb[i], res, ve[i]);
            end
            checks++;
            if (lat !== 2) begin
                failures++;
                $display("FAIL special_latency[%0d] got=%0d want=2", i, lat);
            end
        end
    endtask

    task automatic test_range();
        logic [15:0] res;
        int lat;
        run_op(16'h7BFF, 16'h0001, res, lat);
        checks++;
        if (res !== 16'h7C00) begin
            failures++;
            $display("FAIL overflow_out got=%h want=7c00", res);
        end
        checks++;
        if (lat !== 26) begin
            failures++;
            $display("FAIL overflow_latency got=%0d want=26", lat);
        end
        run_op(16'h0400, 16'h4000, res, lat);
        checks++;
        if (res !== 16'h0200) begin
            failures++;
            $display("FAIL underflow_out got=%h want=0200", res);
        end
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL underflow_latency got=%0d want=17", lat);
        end
    endtask

    task automatic test_subnormal();
        logic [15:0] res;
        int lat;
        run_op(16'h0001, 16'h0001, res, lat);
        checks++;
        if (res !== 16'h3C00) begin
            failures++;
            $display("FAIL subnormal_out got=%h want=3c00", res);
        end
        checks++;
        if (lat !== 36) begin
            failures++;
            $display("FAIL subnormal_latency got=%0d want=36", lat);
        end
    endtask

    task automatic test_rst_abort();
        logic [15:0] res;
        int lat;
        int ndone;
        @(negedge clk);
        in_a  = 16'h3C00;
        in_b  = 16'h4200;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out !== 16'h0000) begin
            failures++;
            $display("FAIL abort_out got=%h want=0000", out);
        end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL abort_no_done got=%0d want=0", ndone);
        end
        run_op(16'h4000, 16'h3C00, res, lat);
        checks++;
        if (res !== 16'h4000) begin
            failures++;
            $display("FAIL after_abort_out got=%h want=4000", res);
        end
        checks++;
        if (lat !== 16) begin
            failures++;
            $display("FAIL after_abort_latency got=%0d want=16", lat);
        end
    endtask

    task automatic test_back_to_back();
        int  pulses;
        int  doubles;
        int  bad_out;
        int  drain;
        bit  prev;
        pulses  = 0;
        doubles = 0;
        bad_out = 0;
        drain   = 0;
        prev    = 1'b0;
        @(negedge clk);
        in_a  = 16'h3C00;
        in_b  = 16'h0000;
        start = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (prev) doubles++;
                if (out !== 16'h7C00) bad_out++;
            end
            prev = done;
        end
        start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) drain++;
        end
        checks++;
        if (pulses !== 13) begin
            failures++;
            $display("FAIL b2b_pulses got=%0d want=13", pulses);
        end
        checks++;
        if (doubles !== 0) begin
            failures++;
            $display("FAIL b2b_wide_done got=%0d want=0", doubles);
        end
        checks++;
        if (bad_out !== 0) begin
            failures++;
            $display("FAIL b2b_out_errors got=%0d want=0", bad_out);
        end
        checks++;
        if (drain !== 1) begin
            failures++;
            $display("FAIL b2b_drain got=%0d want=1", drain);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_a     = 16'h0000;
        in_b     = 16'h0000;
        test_reset();
        test_normal();
        test_specials();
        test_range();
        test_subnormal();
        test_rst_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 SHALL have parameter QNAN_VAL, default 16'h7E00, canonical quiet NaN driven for every invalid result.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in S_IDLE.
REQ-005 SHALL have port in_a  input  16  IEEE 754 binary16 dividend.
REQ-006 SHALL have port in_b  input  16  IEEE 754 binary16 divisor.
REQ-007 SHALL have port out  output  16  quotient; holds its value until the next result is written.
REQ-008 SHALL have port done  output  1  one-cycle pulse; out is valid in that cycle.

Function
REQ-009 SHALL use states S_IDLE, S_INIT, S_PREN, S_CALC, S_NORM, S_PACK, S_SUBN, S_DONE.
REQ-010 SHALL, in S_IDLE with start=1, register in_a/in_b and go to S_INIT; start in any other state SHALL be ignored.
REQ-011 SHALL, in S_INIT, apply specials in priority order:
- either input NaN -> QNAN_VAL
- 0/0 or inf/inf -> QNAN_VAL
- inf/finite -> signed inf
- finite nonzero/0 -> signed inf
- 0/nonzero or finite/inf -> signed zero
Each special writes out and goes to S_DONE.
REQ-012 SHALL set result sign = sign(a) XOR sign(b) for every non-NaN result.
REQ-013 SHALL, for nonzero finite operands, form 11-bit significands with hidden bit = (exp!=0) and effective exponent max(exp,1).
REQ-014 SHALL, in S_PREN, shift each subnormal significand left by one bit per cycle until bit10=1, decrementing its exponent each shift; S_PREN is skipped when both operands are normal.
REQ-015 SHALL compute quotient exponent as signed 7-bit ea - eb + 15.
REQ-016 SHALL, in S_CALC, run a restoring divider producing exactly 12 quotient bits, one per cycle, MSB first: q = floor(ma*2^11/mb); after the 12th bit go to S_NORM.
REQ-017 SHALL, in S_NORM: if q[11]=1, take mantissa q[11:1] with exponent unchanged; else take q[10:0] with exponent-1. Discarded bits are truncated (round toward zero).
REQ-018 SHALL, in S_PACK:
- exponent>=31 -> signed inf
- exponent<=0 -> S_SUBN
- otherwise out = {sign, exp[4:0], mant[9:0]}
REQ-019 SHALL, in S_SUBN, shift mantissa right by 1 and increment exponent per cycle until exponent=1, then emit {sign,5'h00,mant[9:0]}. If the mantissa reaches 0, emit signed zero.
REQ-020 SHALL, in S_DONE, assert done for exactly one cycle and return to S_IDLE; done is 0 in all other cycles.
REQ-021 SHALL have latency, counted from the start-sampling edge to the edge setting done:
- 2 edges for specials
- 16 edges for normal operands with normal result
- plus one edge per S_PREN shift and per S_SUBN shift
REQ-022 SHALL allow a new start in the cycle done is high (FSM is already in S_IDLE).

Reset
REQ-023 SHALL, on rst=1 at any time including mid-operation, force state=S_IDLE, out=16'h0000, done=0, and clear all internal registers; the aborted operation produces no done.
REQ-024 SHALL ignore start while rst=1 and accept start on the first clock edge after rst deasserts.

Structure
REQ-025 SHALL take from shared package fp16_pkg: field widths, bias 15, EXP_MAX 5'h1F, QNAN 16'h7E00, and the state encoding, which is shared with mul.
REQ-026 SHALL instantiate combinational sub-module fp16_classify (zero/subnormal/inf/nan flags, sign/exp/frac split), reusable by mul.
REQ-027 SHALL keep the divider datapath (remainder 13 bits, quotient 12 bits, iteration counter 4 bits) inside div.

Verification
REQ-028 SHALL cover: 0x3C00/0x4200 -> 0x3555 after 16 edges; 0x4600/0xC000 -> 0xC200.
REQ-029 SHALL cover: 0x3C00/0x0000 -> 0x7C00; 0x0000/0x0000 -> 0x7E00; 0x7C00/0xFC00 -> 0x7E00; each with done 2 edges after start.
REQ-030 SHALL cover overflow 0x7BFF/0x0001 -> 0x7C00, and underflow 0x0400/0x4000 -> 0x0200 via S_SUBN.
REQ-031 SHALL cover subnormal dividend 0x0001/0x0001 -> 0x3C00 with latency 16 + 20 edges (10 S_PREN shifts per operand).
REQ-032 SHALL cover rst pulse during S_CALC -> out=0x0000 and no done; the next start 0x4000/0x3C00 -> 0x4000.
REQ-033 SHALL cover start held high for 40 cycles -> back-to-back results, each with exactly one done pulse.
